// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: arbitrates the instruction and data sram-like ports onto a
// single AXI3 master, one single-beat transaction in flight at a time.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        B    = 3'd4
    } state_t;

    state_t      state;
    logic        own_data;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        grant;
    logic        g_wr;
    logic [1:0]  g_size;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        wr_addr_done;
    logic        addr_ok;
    logic        data_ok;
    logic [1:0]  eff_size;
    logic [3:0]  cur_id;

    // Response sideband is irrelevant with a single outstanding transaction.
    logic        unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    // Fixed-priority request select: data port wins over instruction port.
    always_comb begin
        grant   = data_req | inst_req;
        g_wr    = data_req ? data_wr    : inst_wr;
        g_size  = data_req ? data_size  : inst_size;
        g_addr  = data_req ? data_addr  : inst_addr;
        g_wdata = data_req ? data_wdata : inst_wdata;
    end

    // Handshakes and the single-cycle acknowledges derived from them.
    always_comb begin
        ar_hs        = arvalid & arready;
        aw_hs        = awvalid & awready;
        w_hs         = wvalid & wready;
        wr_addr_done = (state == AW) && (awvalid || wvalid)
                       && (aw_hs || !awvalid) && (w_hs || !wvalid);
        addr_ok      = ar_hs | wr_addr_done;
        data_ok      = (rready & rvalid) | (bready & bvalid);
    end

    assign inst_addr_ok = addr_ok & ~own_data;
    assign data_addr_ok = addr_ok &  own_data;
    assign inst_data_ok = data_ok & ~own_data;
    assign data_data_ok = data_ok &  own_data;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // AXI payload taken straight from the latched request.
    always_comb begin
        eff_size = (lat_size == 2'b11) ? 2'b10 : lat_size;
        cur_id   = own_data ? DATA_ID : INST_ID;
        case (eff_size)
            2'd0:    wstrb = 4'b0001 << lat_addr[1:0];
            2'd1:    wstrb = lat_addr[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign arid    = cur_id;
    assign araddr  = lat_addr;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, eff_size};
    assign arburst = 2'b01;
    assign awid    = cur_id;
    assign awaddr  = lat_addr;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, eff_size};
    assign awburst = 2'b01;
    assign wid     = cur_id;
    assign wdata   = lat_wdata;
    assign wlast   = 1'b1;

    // Transaction FSM with registered valid/ready and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own_data  <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        own_data  <= data_req;
                        lat_size  <= g_size;
                        lat_addr  <= g_addr;
                        lat_wdata <= g_wdata;
                        arvalid   <= ~g_wr;
                        awvalid   <= g_wr;
                        wvalid    <= g_wr;
                        state     <= g_wr ? AW : AR;
                    end
                end
                AR: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                AW: begin
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs)  wvalid  <= 1'b0;
                    if (wr_addr_done) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: scoreboard bench with a latency-configurable AXI slave.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;

    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic        rvalid = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'd0;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(4'd0), .rdata(rdata), .rresp(2'd0), .rlast(1'b1),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(4'd0), .bresp(2'd0), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference models
    function automatic logic [31:0] rmodel(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    function automatic logic [2:0] exp_axsize(input logic [1:0] s);
        return (s == 2'd3) ? 3'd2 : {1'b0, s};
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] s, input logic [1:0] a);
        if (s == 2'd0) begin
            case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (s == 2'd1) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned issue;
        int unsigned ao_lat;
        int unsigned do_lat;
    } txn_t;

    txn_t q_inst[$];
    txn_t q_data[$];
    bit   pend_inst = 0, pend_data = 0;
    int unsigned ao_cyc_inst = 0, ao_cyc_data = 0, do_cyc_data = 0;

    // AXI slave: each channel accepts after a programmable number of stall cycles
    int unsigned ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
    int unsigned ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic [31:0] sl_raddr = 32'd0;

    always @(negedge clk) begin
        if (rst) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        end else begin
            arready = 0;
            if (arvalid) begin
                if (ar_cnt >= ar_lat) begin arready = 1; ar_cnt = 0; sl_raddr = araddr; end
                else ar_cnt++;
            end
            awready = 0;
            if (awvalid) begin
                if (aw_cnt >= aw_lat) begin awready = 1; aw_cnt = 0; end
                else aw_cnt++;
            end
            wready = 0;
            if (wvalid) begin
                if (w_cnt >= w_lat) begin wready = 1; w_cnt = 0; end
                else w_cnt++;
            end
            rvalid = 0;
            if (rready) begin
                if (r_cnt >= r_lat) begin rvalid = 1; r_cnt = 0; rdata = rmodel(sl_raddr); end
                else r_cnt++;
            end
            bvalid = 0;
            if (bready) begin
                if (b_cnt >= b_lat) begin bvalid = 1; b_cnt = 0; end
                else b_cnt++;
            end
        end
    end

    // Scoreboard: address-phase acknowledge
    task automatic on_addr_ok(input bit d);
        txn_t t;
        check(d ? "data_addr_ok_expected" : "inst_addr_ok_expected",
              32'(d ? q_data.size() != 0 : q_inst.size() != 0), 32'd1);
        if (d ? q_data.size() == 0 : q_inst.size() == 0) return;
        t = d ? q_data[0] : q_inst[0];
        check("addr_ok_not_repeated", 32'(d ? pend_data : pend_inst), 32'd0);
        if (d) begin pend_data = 1; ao_cyc_data = cyc; end
        else   begin pend_inst = 1; ao_cyc_inst = cyc; end
        if (t.ao_lat != 0) check("addr_ok_latency", cyc - t.issue, t.ao_lat);
        if (t.wr) begin
            check("awaddr", awaddr, t.addr);
            check("awsize", 32'(awsize), 32'(exp_axsize(t.size)));
            check("wstrb", 32'(wstrb), 32'(exp_strb(t.size, t.addr[1:0])));
            check("wdata", wdata, t.wdata);
            check("awid", 32'(awid), d ? 32'd1 : 32'd0);
            check("wid", 32'(wid), d ? 32'd1 : 32'd0);
            check("aw_fixed", {awlen, 2'b00, awburst, 7'd0, wlast}, {4'd0, 2'b00, 2'b01, 7'd0, 1'b1});
        end else begin
            check("araddr", araddr, t.addr);
            check("arsize", 32'(arsize), 32'(exp_axsize(t.size)));
            check("arid", 32'(arid), d ? 32'd1 : 32'd0);
            check("ar_fixed", {arlen, 2'b00, arburst}, {4'd0, 2'b00, 2'b01});
        end
    endtask

    // Scoreboard: data-phase acknowledge
    task automatic on_data_ok(input bit d);
        txn_t t;
        check("data_ok_after_addr_ok", 32'(d ? pend_data : pend_inst), 32'd1);
        if (d ? !pend_data : !pend_inst) return;
        check("addr_ok_before_data_ok", 32'(cyc > (d ? ao_cyc_data : ao_cyc_inst)), 32'd1);
        t = d ? q_data.pop_front() : q_inst.pop_front();
        if (d) begin pend_data = 0; do_cyc_data = cyc; end
        else   pend_inst = 0;
        if (t.do_lat != 0) check("data_ok_latency", cyc - t.issue, t.do_lat);
        if (!t.wr) check(d ? "data_rdata" : "inst_rdata", d ? data_rdata : inst_rdata, t.rdata);
    endtask

    // Output monitor, sampled mid-low-phase after the slave has responded
    logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            p_arv = 0; p_awv = 0; p_wv = 0;
        end else begin
            if (inst_addr_ok | data_addr_ok | inst_data_ok | data_data_ok)
                check("ack_onehot", 32'($countones({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok})), 32'd1);
            if (arvalid | awvalid | wvalid)
                check("ar_aw_exclusive", 32'(arvalid & (awvalid | wvalid)), 32'd0);
            if (p_arv && !p_arr) begin
                check("arvalid_hold", 32'(arvalid), 32'd1);
                check("araddr_hold", araddr, p_araddr);
            end
            if (p_awv && !p_awr) begin
                check("awvalid_hold", 32'(awvalid), 32'd1);
                check("awaddr_hold", awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                check("wvalid_hold", 32'(wvalid), 32'd1);
                check("wdata_hold", wdata, p_wdata);
            end
            if (data_addr_ok) on_addr_ok(1'b1);
            if (inst_addr_ok) on_addr_ok(1'b0);
            if (data_data_ok) on_data_ok(1'b1);
            if (inst_data_ok) on_data_ok(1'b0);
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv  = wvalid;  p_wr  = wready;  p_wdata  = wdata;
        end
    end

    // Drive one sram-like request; returns at posedge+1 after its addr_ok
    task automatic issue(input bit d, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int unsigned ao, input int unsigned dl);
        txn_t t;
        bit   got;
        t.wr = wr; t.size = sz; t.addr = a; t.wdata = wd; t.rdata = rmodel(a);
        t.issue = cyc; t.ao_lat = ao; t.do_lat = dl;
        if (d) begin
            q_data.push_back(t);
            data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        end else begin
            q_inst.push_back(t);
            inst_req = 1; inst_wr = wr; inst_size = sz; inst_addr = a; inst_wdata = wd;
        end
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk); #2;
            got = d ? data_addr_ok : inst_addr_ok;
        end
        if (!got) check("addr_ok_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (d) data_req = 0; else inst_req = 0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((q_inst.size() + q_data.size()) != 0 && n < 300) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain", 32'(q_inst.size() + q_data.size()), 32'd0);
    endtask

    task automatic set_lat(input int unsigned a, input int unsigned aw,
                           input int unsigned w, input int unsigned r, input int unsigned b);
        ar_lat = a; aw_lat = aw; w_lat = w; r_lat = r; b_lat = b;
    endtask

    initial begin
        int unsigned n0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
        check("rst_readies", 32'({rready, bready}), 32'd0);
        check("rst_acks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Zero-wait data read
        set_lat(0, 0, 0, 0, 0);
        issue(1, 0, 2'd2, 32'h0000_1004, 32'd0, 1, 2);
        wait_drain();

        // Byte store with awready three cycles late
        set_lat(0, 3, 0, 0, 0);
        @(posedge clk); #1;
        n0 = cyc;
        fork
            issue(1, 1, 2'd0, 32'h0000_2003, 32'h1122_3344, 4, 5);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk); #1;
                check("wvalid_dropped", 32'(wvalid), 32'd0);
                check("awvalid_still_up", 32'(awvalid), 32'd1);
                check("store_start_cycle", cyc - n0, 32'd2);
            end
        join
        wait_drain();

        // Simultaneous requests: data first, inst after data_ok + IDLE
        set_lat(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        fork
            issue(1, 0, 2'd2, 32'h0000_4000, 32'd0, 1, 2);
            issue(0, 0, 2'd2, 32'h0000_5000, 32'd0, 0, 0);
        join
        wait_drain();
        check("inst_after_data", ao_cyc_inst - do_cyc_data, 32'd2);

        // Write-back miss: write then read on the data port
        @(posedge clk); #1;
        issue(1, 1, 2'd2, 32'h0000_3000, 32'hCAFE_F00D, 1, 2);
        issue(1, 0, 2'd2, 32'h0000_7000, 32'd0, 0, 0);
        wait_drain();

        // Read address backpressure for 5 cycles
        set_lat(5, 0, 0, 0, 0);
        @(posedge clk); #1;
        issue(0, 0, 2'd1, 32'h0000_6002, 32'd0, 6, 7);
        wait_drain();

        // Reset while waiting in R
        set_lat(0, 0, 0, 50, 0);
        @(posedge clk); #1;
        issue(1, 0, 2'd2, 32'h0000_8000, 32'd0, 1, 0);
        @(posedge clk); #1;
        rst = 1;
        q_data.delete();
        pend_data = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
        check("post_rst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
        check("post_rst_readies", 32'({rready, bready}), 32'd0);
        check("post_rst_acks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        set_lat(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        issue(1, 0, 2'd2, 32'h0000_9000, 32'd0, 1, 2);
        wait_drain();

        // Mixed traffic across sizes, ports and latencies
        for (int k = 0; k < 16; k++) begin
            set_lat($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2));
            @(posedge clk); #1;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, 0, 0);
            wait_drain();
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the two sram-like cache-side ports (instruction cache and write-back data cache) into a single AXI3 master, one transaction in flight at a time. Sits directly downstream of the data cache and instruction cache, and upstream of the AXI crossbar and memory. Each sram-like request becomes exactly one single-beat AXI read or write.

## Interface
Parameters:
- INST_ID, 4'd0, ARID used for instruction-port reads.
- DATA_ID, 4'd1, ARID/AWID/WID used for data-port transactions.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-high.
- inst_req, inst_wr  in  1 each  instruction-port request and write flag.
- inst_size  in  2  access size.
- inst_addr, inst_wdata  in  32 each  address and write data.
- inst_rdata  out  32  read data.
- inst_addr_ok, inst_data_ok  out  1 each  single-cycle acknowledges.
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok  same widths and directions as the inst_ signals, for the data port.
- arid  out  4;  araddr  out  32;  arlen  out  4 (always 0);  arsize  out  3;  arburst  out  2 (always 2'b01);  arvalid  out  1;  arready  in  1.
- rid  in  4;  rdata  in  32;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1.
- awid  out  4;  awaddr  out  32;  awlen  out  4 (always 0);  awsize  out  3;  awburst  out  2 (always 2'b01);  awvalid  out  1;  awready  in  1.
- wid  out  4;  wdata  out  32;  wstrb  out  4;  wlast  out  1 (always 1);  wvalid  out  1;  wready  in  1.
- bid  in  4;  bresp  in  2;  bvalid  in  1;  bready  out  1.

## Operation
- FSM states: IDLE, AR, R, AW, B. The reset state is IDLE.
- IDLE behaviour:
  - If data_req=1, grant the data port; otherwise, if inst_req=1, grant the inst port.
  - Fixed priority: data beats inst.
  - On grant, latch owner, wr, size, addr and wdata into registers.
  - Next state is AW if wr=1, else AR.
- AR state:
  - arvalid=1, driven from the latched registers.
  - On arvalid&arready, pulse the owner's addr_ok for that same cycle and go to R.
- R state:
  - rready=1.
  - On rvalid, pulse the owner's data_ok and go to IDLE.
  - rid, rresp and rlast are ignored, because only one transaction is ever outstanding.
- AW state:
  - awvalid and wvalid both rise on entry.
  - Each drops independently after its own handshake.
  - The owner's addr_ok pulses in the cycle the later of the two handshakes completes (or the common cycle if both complete together). The FSM then goes to B.
- B state:
  - bready=1.
  - On bvalid, pulse the owner's data_ok and go to IDLE.
  - bresp is ignored.
- Size mapping: arsize/awsize = {1'b0, size}; size 2'b11 is treated as 2'b10.
- Write strobe (wstrb) from size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b1100 if addr[1]=1, else 4'b0011.
  - size 2: 4'b1111.
- araddr and awaddr are the latched address, unmodified.
- inst_rdata and data_rdata are combinational copies of rdata. They are meaningful only in the data_ok cycle, because the caches capture read data in that cycle.
- The non-granted port is never acknowledged. Its req stays high and it is served from a later IDLE.

## Timing
- Reset values:
  - All valid and ready outputs = 0.
  - All addr_ok and data_ok outputs = 0.
  - Latched registers = 0.
- addr_ok and data_ok are exactly one cycle wide and never asserted in IDLE.
- addr_ok always precedes data_ok by at least 1 cycle.
- Zero-wait slave, read:
  - req seen at cycle 0.
  - arvalid and addr_ok at cycle 1.
  - rvalid and data_ok at cycle 2.
  - IDLE at cycle 3.
- Zero-wait slave, write: addr_ok at cycle 1, data_ok at cycle 2.
- Back-to-back transactions: a new grant is possible in the IDLE cycle immediately after data_ok. Minimum transaction period is 3 cycles.
- Valid stability: arvalid, awvalid and wvalid, once asserted, stay high with stable payload until their handshake completes. They are never withdrawn.
- Reset mid-transaction: all outputs return to reset values on the next edge, and the FSM returns to IDLE. The AXI slave shares rst, so no pending beat is drained.
- Inputs are sampled only in IDLE; req, addr and wdata changes while busy are ignored.

## Test plan
- Data read, zero-wait: data_req=1, data_wr=0, data_addr=32'h0000_1004, size=2, with arready=rvalid=1 and rdata=32'hDEAD_BEEF → araddr=32'h0000_1004 and arid=1 at cycle 1, data_addr_ok at cycle 1, data_data_ok with data_rdata=32'hDEAD_BEEF at cycle 2.
- Byte store: data_wr=1, size=0, addr=32'h0000_2003, wdata=32'h1122_3344 → wstrb=4'b1000, awsize=0. With awready late by 3 cycles and wready immediate, wvalid drops after 1 cycle, addr_ok appears on the awready cycle, data_ok follows bvalid.
- Simultaneous requests: inst_req=data_req=1 in the same cycle → data is granted first, and inst_addr_ok is first seen only after data_data_ok plus 1 cycle, with arid=0.
- Write-back miss sequence, as the data cache produces it: a write to 32'h0000_3000 followed by a read of 32'h0000_7000 → two separate transactions in order, each with its own addr_ok/data_ok pair, and AW never overlapping AR.
- Slave backpressure: arready held 0 for 5 cycles → arvalid and araddr stay constant for all 5 cycles, and no addr_ok is issued until arready=1.
- Reset in R state: assert rst while waiting for rvalid → arvalid, rready and all ok signals are 0 on the next edge and the FSM is in IDLE. A subsequent read completes normally.
